// File: rtl/weighted_sum_sequencer.sv
`default_nettype none
// weighted_sum_sequencer: issues N data/weight pairs to a pipelined multiplier and accumulates the
// returned products. Define SEQ_SATURATE_EN to clamp the sum on overflow instead of wrapping.
module weighted_sum_sequencer #(
  parameter int N       = 4,
  parameter int DW      = 13,
  parameter int ACC_W   = 13,
  parameter int MAC_LAT = 2
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                start,
  input  logic [N*DW-1:0]     data_in,
  input  logic [N*DW-1:0]     wght_in,
  output logic                busy,
  output logic                mac_issue,
  output logic [DW-1:0]       mac_a,
  output logic [DW-1:0]       mac_b,
  input  logic [2*DW-1:0]     mac_p,
  input  logic                mac_p_vld,
  output logic [ACC_W-1:0]    res,
  output logic                res_vld,
  input  logic                res_rdy,
  output logic                ovf
);

  localparam int CW = (N < 2) ? 1 : $clog2(N + 1);
  localparam int SW = ACC_W + 2 * DW + 1;

  if (N < 1 || MAC_LAT < 1) begin : g_param_check
    $error("weighted_sum_sequencer: N and MAC_LAT must both be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [N*DW-1:0]   d_lat, d_lat_n;
  logic [N*DW-1:0]   w_lat, w_lat_n;
  logic [CW-1:0]     idx, idx_n;
  logic [CW-1:0]     rcv_cnt, rcv_n;
  logic [ACC_W-1:0]  acc, acc_n;
  logic              ovf_n;
  logic [ACC_W-1:0]  res_n;
  logic              res_vld_n;
  logic              busy_n;
  logic              issue_n;
  logic [DW-1:0]     a_n, b_n;
  logic [SW-1:0]     sum;
  logic [ACC_W-1:0]  acc_add;
  logic              ovf_add;
`ifdef SEQ_SATURATE_EN
  logic              clamp, clamp_n;
`endif

  always_comb begin
    state_n   = state;
    d_lat_n   = d_lat;
    w_lat_n   = w_lat;
    idx_n     = idx;
    rcv_n     = rcv_cnt;
    acc_n     = acc;
    ovf_n     = ovf;
    res_n     = res;
    res_vld_n = res_vld;
    issue_n   = 1'b0;
    a_n       = mac_a;
    b_n       = mac_b;
    // Full-width sum so any carry beyond ACC_W is visible as overflow.
    sum       = SW'(acc) + SW'(mac_p);
    acc_add   = sum[ACC_W-1:0];
    ovf_add   = |sum[SW-1:ACC_W];
`ifdef SEQ_SATURATE_EN
    clamp_n   = clamp;
    if (clamp || ovf_add) acc_add = '1;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          d_lat_n = data_in;
          w_lat_n = wght_in;
          acc_n   = '0;
          rcv_n   = '0;
          ovf_n   = 1'b0;
          // Pair 0 goes out straight from the inputs so issue starts the cycle after start.
          issue_n = 1'b1;
          a_n     = data_in[DW-1:0];
          b_n     = wght_in[DW-1:0];
          idx_n   = CW'(1);
          state_n = ISSUE;
`ifdef SEQ_SATURATE_EN
          clamp_n = 1'b0;
`endif
        end
      end
      ISSUE, DRAIN: begin
        if (state == ISSUE) begin
          if (idx < CW'(N)) begin
            issue_n = 1'b1;
            a_n     = d_lat[int'(idx)*DW +: DW];
            b_n     = w_lat[int'(idx)*DW +: DW];
            idx_n   = idx + 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
        if (mac_p_vld) begin
          acc_n = acc_add;
          ovf_n = ovf | ovf_add;
          rcv_n = rcv_cnt + 1'b1;
`ifdef SEQ_SATURATE_EN
          clamp_n = clamp | ovf_add;
`endif
          if (rcv_cnt == CW'(N - 1)) begin
            res_n     = acc_add;
            res_vld_n = 1'b1;
            state_n   = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_vld && res_rdy) begin
          res_vld_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state     <= IDLE;
      d_lat     <= '0;
      w_lat     <= '0;
      idx       <= '0;
      rcv_cnt   <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      res       <= '0;
      res_vld   <= 1'b0;
      busy      <= 1'b0;
      mac_issue <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
`ifdef SEQ_SATURATE_EN
      clamp     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      d_lat     <= d_lat_n;
      w_lat     <= w_lat_n;
      idx       <= idx_n;
      rcv_cnt   <= rcv_n;
      acc       <= acc_n;
      ovf       <= ovf_n;
      res       <= res_n;
      res_vld   <= res_vld_n;
      busy      <= busy_n;
      mac_issue <= issue_n;
      mac_a     <= a_n;
      mac_b     <= b_n;
`ifdef SEQ_SATURATE_EN
      clamp     <= clamp_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weighted_sum_sequencer.sv
`default_nettype none
// Bench for weighted_sum_sequencer: directed runs feed a result scoreboard checked on each handshake.
module tb_weighted_sum_sequencer;

  localparam int N       = 4;
  localparam int DW      = 13;
  localparam int ACC_W   = 13;
  localparam int MAC_LAT = 2;
  localparam int EXP_LAT = N + MAC_LAT + 1;
`ifdef SEQ_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  logic clk  = 1'b0;
  logic rest = 1'b0;
  always #5 clk = ~clk;

  // Main instance, N=4
  logic              start, res_rdy;
  logic [N*DW-1:0]   data_in, wght_in;
  logic              busy, mac_issue, mac_p_vld, res_vld, ovf;
  logic [DW-1:0]     mac_a, mac_b;
  logic [2*DW-1:0]   mac_p;
  logic [ACC_W-1:0]  res;

  // Second instance, N=1
  logic              start1;
  logic              rdy1 = 1'b1;
  logic [DW-1:0]     data1, wght1;
  logic              busy1, issue1, pv1, rv1, ovf1;
  logic [DW-1:0]     a1, b1;
  logic [2*DW-1:0]   p1;
  logic [ACC_W-1:0]  res1;

  weighted_sum_sequencer #(.N(N), .DW(DW), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) u_dut (
    .clk(clk), .rest(rest), .start(start), .data_in(data_in), .wght_in(wght_in),
    .busy(busy), .mac_issue(mac_issue), .mac_a(mac_a), .mac_b(mac_b),
    .mac_p(mac_p), .mac_p_vld(mac_p_vld), .res(res), .res_vld(res_vld),
    .res_rdy(res_rdy), .ovf(ovf)
  );

  weighted_sum_sequencer #(.N(1), .DW(DW), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) u_dut1 (
    .clk(clk), .rest(rest), .start(start1), .data_in(data1), .wght_in(wght1),
    .busy(busy1), .mac_issue(issue1), .mac_a(a1), .mac_b(b1),
    .mac_p(p1), .mac_p_vld(pv1), .res(res1), .res_vld(rv1),
    .res_rdy(rdy1), .ovf(ovf1)
  );

  // Multiplier models: MAC_LAT-stage pipelines, deliberately not reset so late products survive.
  logic [MAC_LAT-1:0] pv0_q = '0;
  logic [MAC_LAT-1:0] pv1_q = '0;
  logic [2*DW-1:0]    pp0_q [MAC_LAT];
  logic [2*DW-1:0]    pp1_q [MAC_LAT];

  always @(posedge clk) begin
    pv0_q[0] <= mac_issue;
    pp0_q[0] <= {{DW{1'b0}}, mac_a} * {{DW{1'b0}}, mac_b};
    pv1_q[0] <= issue1;
    pp1_q[0] <= {{DW{1'b0}}, a1} * {{DW{1'b0}}, b1};
    for (int i = 1; i < MAC_LAT; i++) begin
      pv0_q[i] <= pv0_q[i-1];
      pp0_q[i] <= pp0_q[i-1];
      pv1_q[i] <= pv1_q[i-1];
      pp1_q[i] <= pp1_q[i-1];
    end
  end

  assign mac_p     = pp0_q[MAC_LAT-1];
  assign mac_p_vld = pv0_q[MAC_LAT-1];
  assign p1        = pp1_q[MAC_LAT-1];
  assign pv1       = pv1_q[MAC_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  // Scoreboard
  logic [ACC_W-1:0] sb_res [$];
  logic             sb_ovf [$];
  logic [ACC_W-1:0] mon_er;
  logic             mon_eo;

  always @(negedge clk) begin
    if (rest && res_vld && res_rdy) begin
      if (sb_res.size() == 0) begin
        chk("sb_unexpected_result", 1, 0);
      end else begin
        mon_er = sb_res.pop_front();
        mon_eo = sb_ovf.pop_front();
        chk("sb_res", res, mon_er);
        chk("sb_ovf", ovf, mon_eo);
      end
    end
  end

  // Called just after a rising edge in IDLE; returns after the handshake (or at res_vld if res_rdy=0).
  task automatic run(input logic [N*DW-1:0] d, input logic [N*DW-1:0] w,
                     input int exp_res, input logic exp_ovf);
    logic [31:0] mask;
    int          lat;
    mask = '0;
    lat  = 0;
    data_in = d;
    wght_in = w;
    start   = 1'b1;
    sb_res.push_back(ACC_W'(exp_res));
    sb_ovf.push_back(exp_ovf);
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (mac_issue) mask[k] = 1'b1;
      if (res_vld) lat = k;
    end
    chk("latency", lat, EXP_LAT);
    chk("issue_cycles", mask, 32'h1E);
    if (res_rdy) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mask1;
    int          lat1;
    start   = 1'b0;
    res_rdy = 1'b1;
    data_in = '0;
    wght_in = '0;
    start1  = 1'b0;
    data1   = '0;
    wght1   = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mac_issue", mac_issue, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_res", res, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1 rest = 1'b1;
    @(posedge clk); #1;

    run(pk(1, 2, 3, 4), pk(12, 6, 4, 3), 48, 1'b0);
    run(pk(100, 100, 100, 100), pk(100, 100, 100, 100), SAT ? 8191 : 7232, 1'b1);
    // Back-to-back: start in the first IDLE cycle, overflow flag must clear
    run(pk(1, 2, 3, 4), pk(12, 6, 4, 3), 48, 1'b0);
    run(pk(8191, 0, 0, 0), pk(1, 0, 0, 0), 8191, 1'b0);
    run(pk(8191, 1, 0, 0), pk(1, 1, 0, 0), SAT ? 8191 : 0, 1'b1);

    // Display driver stalls; start pulses must be ignored
    res_rdy = 1'b0;
    run(pk(10, 20, 30, 40), pk(1, 1, 1, 1), 100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 start = (i % 3 == 0);
      @(negedge clk);
      chk("hold_res_vld", res_vld, 1);
      chk("hold_res", res, 100);
      chk("hold_no_issue", mac_issue, 0);
      chk("hold_busy", busy, 1);
    end
    @(posedge clk); #1 start = 1'b1; res_rdy = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_accept_busy", busy, 0);
      chk("post_accept_res_vld", res_vld, 0);
      chk("post_accept_no_issue", mac_issue, 0);
    end
    chk("post_accept_res_kept", res, 100);

    // Reset during the second ISSUE cycle
    @(posedge clk); #1;
    data_in = pk(1, 2, 3, 4);
    wght_in = pk(12, 6, 4, 3);
    start   = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rest = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mac_issue", mac_issue, 0);
    chk("abort_mac_a", mac_a, 0);
    chk("abort_mac_b", mac_b, 0);
    chk("abort_res", res, 0);
    chk("abort_res_vld", res_vld, 0);
    chk("abort_ovf", ovf, 0);
    @(posedge clk); #1 rest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("after_abort_busy", busy, 0);
      chk("after_abort_res_vld", res_vld, 0);
    end
    @(posedge clk); #1;
    run(pk(2, 3, 4, 5), pk(6, 7, 8, 9), 110, 1'b0);

    // Single-pair instance
    data1  = DW'(5);
    wght1  = DW'(7);
    start1 = 1'b1;
    mask1  = '0;
    lat1   = 0;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 1; k <= 20 && lat1 == 0; k++) begin
      @(negedge clk);
      if (issue1) mask1[k] = 1'b1;
      if (rv1) lat1 = k;
    end
    chk("n1_issue_cycles", mask1, 32'h2);
    chk("n1_latency", lat1, MAC_LAT + 2);
    chk("n1_res", res1, 35);
    chk("n1_ovf", ovf1, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
